// File: rtl/add_rs_if.sv
// Issue, CDB and ALU-dispatch signal bundle for the add/sub reservation station.
// The slave modport is the station; the master modport is its environment.
interface add_rs_if #(
   parameter int unsigned TAG_W = 3
) ();
   logic             issueEN;
   logic             issueOp;
   logic [TAG_W-1:0] issueQj;
   logic [TAG_W-1:0] issueQk;
   logic [31:0]      issueVj;
   logic [31:0]      issueVk;
   logic             issueFull;
   logic [TAG_W-1:0] issueTag;

   logic             cdbEN;
   logic [TAG_W-1:0] cdbTag;
   logic [31:0]      cdbData;

   logic             aluEN;
   logic             aluReady;
   logic             aluOp;
   logic [31:0]      aluData1;
   logic [31:0]      aluData2;
   logic [TAG_W-1:0] aluTag;

   modport master (
      output issueEN, issueOp, issueQj, issueQk, issueVj, issueVk,
      input  issueFull, issueTag,
      output cdbEN, cdbTag, cdbData,
      input  aluEN, aluOp, aluData1, aluData2, aluTag,
      output aluReady
   );

   modport slave (
      input  issueEN, issueOp, issueQj, issueQk, issueVj, issueVk,
      output issueFull, issueTag,
      input  cdbEN, cdbTag, cdbData,
      output aluEN, aluOp, aluData1, aluData2, aluTag,
      input  aluReady
   );
endinterface

// File: rtl/add_rs.sv
// Add/sub reservation station: issue, CDB snoop, lowest-index dispatch, release on CDB.
// Optional ADDRS_ISSUE_BYPASS_EN offers a fully-ready issue to the ALU in its own cycle.
module add_rs #(
   parameter int unsigned NUM_ENTRY = 3,
   parameter int unsigned TAG_W     = 3,
   parameter int unsigned BASE_TAG  = 1
) (
   input logic     clk,
   input logic     RST,
   add_rs_if.slave bus
);

   localparam int unsigned IdxW = (NUM_ENTRY > 1) ? $clog2(NUM_ENTRY) : 1;

   typedef enum logic [1:0] {StFree, StWait, StReady, StExec} state_e;

   state_e           r_state [NUM_ENTRY];
   logic             r_op    [NUM_ENTRY];
   logic [TAG_W-1:0] r_qj    [NUM_ENTRY];
   logic [TAG_W-1:0] r_qk    [NUM_ENTRY];
   logic [31:0]      r_vj    [NUM_ENTRY];
   logic [31:0]      r_vk    [NUM_ENTRY];

   logic             w_any_free;
   logic             w_any_rdy;
   logic [IdxW-1:0]  w_free_idx;
   logic [IdxW-1:0]  w_rdy_idx;

   logic             w_cap_j;
   logic             w_cap_k;
   logic [TAG_W-1:0] w_iss_qj;
   logic [TAG_W-1:0] w_iss_qk;
   logic [31:0]      w_iss_vj;
   logic [31:0]      w_iss_vk;
   logic             w_iss_acc;
   logic             w_iss_rdy;
   logic             w_byp;
   logic             w_disp;

   logic [TAG_W-1:0] w_qj_nx [NUM_ENTRY];
   logic [TAG_W-1:0] w_qk_nx [NUM_ENTRY];
   logic [31:0]      w_vj_nx [NUM_ENTRY];
   logic [31:0]      w_vk_nx [NUM_ENTRY];

   function automatic logic [TAG_W-1:0] entry_tag(input int idx);
      return TAG_W'(BASE_TAG + idx);
   endfunction

   // Scan downwards so the last hit is the lowest index.
   always_comb begin
      w_any_free = 1'b0;
      w_free_idx = '0;
      w_any_rdy  = 1'b0;
      w_rdy_idx  = '0;
      for (int i = int'(NUM_ENTRY) - 1; i >= 0; i--) begin
         if (r_state[i] == StFree) begin
            w_any_free = 1'b1;
            w_free_idx = IdxW'(i);
         end
         if (r_state[i] == StReady) begin
            w_any_rdy = 1'b1;
            w_rdy_idx = IdxW'(i);
         end
      end
   end

   always_comb begin
      w_cap_j   = bus.cdbEN && (bus.issueQj != '0) && (bus.cdbTag == bus.issueQj);
      w_cap_k   = bus.cdbEN && (bus.issueQk != '0) && (bus.cdbTag == bus.issueQk);
      w_iss_qj  = w_cap_j ? '0 : bus.issueQj;
      w_iss_qk  = w_cap_k ? '0 : bus.issueQk;
      w_iss_vj  = w_cap_j ? bus.cdbData : bus.issueVj;
      w_iss_vk  = w_cap_k ? bus.cdbData : bus.issueVk;
      w_iss_acc = bus.issueEN && w_any_free;
      w_iss_rdy = (w_iss_qj == '0) && (w_iss_qk == '0);
   end

`ifdef ADDRS_ISSUE_BYPASS_EN
   assign w_byp = w_iss_acc && w_iss_rdy && !w_any_rdy && !RST;
`else
   assign w_byp = 1'b0;
`endif

   always_comb begin
      bus.aluEN    = 1'b0;
      bus.aluOp    = 1'b0;
      bus.aluData1 = '0;
      bus.aluData2 = '0;
      bus.aluTag   = '0;
      if (w_any_rdy) begin
         bus.aluEN    = 1'b1;
         bus.aluOp    = r_op[w_rdy_idx];
         bus.aluData1 = r_vj[w_rdy_idx];
         bus.aluData2 = r_vk[w_rdy_idx];
         bus.aluTag   = entry_tag(int'(w_rdy_idx));
      end else if (w_byp) begin
         bus.aluEN    = 1'b1;
         bus.aluOp    = bus.issueOp;
         bus.aluData1 = w_iss_vj;
         bus.aluData2 = w_iss_vk;
         bus.aluTag   = entry_tag(int'(w_free_idx));
      end
   end

   assign w_disp        = bus.aluEN && bus.aluReady;
   assign bus.issueFull = !w_any_free;
   assign bus.issueTag  = w_any_free ? entry_tag(int'(w_free_idx)) : '0;

   // Operand snoop; tag 0 never matches so a valid operand is never overwritten.
   always_comb begin
      for (int i = 0; i < int'(NUM_ENTRY); i++) begin
         w_qj_nx[i] = r_qj[i];
         w_qk_nx[i] = r_qk[i];
         w_vj_nx[i] = r_vj[i];
         w_vk_nx[i] = r_vk[i];
         if (bus.cdbEN && (r_qj[i] != '0) && (r_qj[i] == bus.cdbTag)) begin
            w_qj_nx[i] = '0;
            w_vj_nx[i] = bus.cdbData;
         end
         if (bus.cdbEN && (r_qk[i] != '0) && (r_qk[i] == bus.cdbTag)) begin
            w_qk_nx[i] = '0;
            w_vk_nx[i] = bus.cdbData;
         end
      end
   end

   always_ff @(posedge clk or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < int'(NUM_ENTRY); i++) begin
            r_state[i] <= StFree;
            r_op[i]    <= 1'b0;
            r_qj[i]    <= '0;
            r_qk[i]    <= '0;
            r_vj[i]    <= '0;
            r_vk[i]    <= '0;
         end
      end else begin
         for (int i = 0; i < int'(NUM_ENTRY); i++) begin
            unique case (r_state[i])
               StFree: begin
                  if (w_iss_acc && (int'(w_free_idx) == i)) begin
                     r_op[i] <= bus.issueOp;
                     r_qj[i] <= w_iss_qj;
                     r_qk[i] <= w_iss_qk;
                     r_vj[i] <= w_iss_vj;
                     r_vk[i] <= w_iss_vk;
                     if (w_byp && bus.aluReady) begin
                        r_state[i] <= StExec;
                     end else if (w_iss_rdy) begin
                        r_state[i] <= StReady;
                     end else begin
                        r_state[i] <= StWait;
                     end
                  end
               end
               StWait: begin
                  r_qj[i] <= w_qj_nx[i];
                  r_qk[i] <= w_qk_nx[i];
                  r_vj[i] <= w_vj_nx[i];
                  r_vk[i] <= w_vk_nx[i];
                  if ((w_qj_nx[i] == '0) && (w_qk_nx[i] == '0)) begin
                     r_state[i] <= StReady;
                  end
               end
               StReady: begin
                  if (w_disp && w_any_rdy && (int'(w_rdy_idx) == i)) begin
                     r_state[i] <= StExec;
                  end
               end
               StExec: begin
                  if (bus.cdbEN && (bus.cdbTag == entry_tag(i))) begin
                     r_state[i] <= StFree;
                  end
               end
               default: r_state[i] <= StFree;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_add_rs.sv
// Directed self-checking bench for add_rs in its default (no issue bypass) build.
module tb_add_rs;

   logic clk;
   logic RST;
   int   total;
   int   bad;

   add_rs_if #(.TAG_W(3)) bus ();

   add_rs #(
      .NUM_ENTRY(3),
      .TAG_W    (3),
      .BASE_TAG (1)
   ) dut (
      .clk(clk),
      .RST(RST),
      .bus(bus)
   );

   // {aluEN, aluOp, aluTag, aluData1, aluData2} and {issueFull, issueTag}
   logic [68:0] alu_o;
   logic [3:0]  iss_o;
   assign alu_o = {bus.aluEN, bus.aluOp, bus.aluTag, bus.aluData1, bus.aluData2};
   assign iss_o = {bus.issueFull, bus.issueTag};

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1);
   end

   task automatic idle();
      bus.issueEN = 1'b0;
      bus.issueOp = 1'b0;
      bus.issueQj = '0;
      bus.issueQk = '0;
      bus.issueVj = '0;
      bus.issueVk = '0;
      bus.cdbEN   = 1'b0;
      bus.cdbTag  = '0;
      bus.cdbData = '0;
   endtask

   task automatic drive_issue(input logic op, input logic [2:0] qj, input logic [31:0] vj,
                              input logic [2:0] qk, input logic [31:0] vk);
      bus.issueEN = 1'b1;
      bus.issueOp = op;
      bus.issueQj = qj;
      bus.issueVj = vj;
      bus.issueQk = qk;
      bus.issueVk = vk;
   endtask

   task automatic drive_cdb(input logic [2:0] tag, input logic [31:0] data);
      bus.cdbEN   = 1'b1;
      bus.cdbTag  = tag;
      bus.cdbData = data;
   endtask

   task automatic apply_reset();
      RST = 1'b1;
      idle();
      bus.aluReady = 1'b0;
      @(negedge clk);
      @(negedge clk);
      RST = 1'b0;
   endtask

   task automatic test_reset();
      RST = 1'b1;
      idle();
      bus.aluReady = 1'b1;
      @(negedge clk);
      #1;
      total++;
      if (alu_o !== 69'd0) begin
         bad++;
         $display("FAIL reset_alu got=%h want=0", alu_o);
      end
      total++;
      if (iss_o !== {1'b0, 3'd1}) begin
         bad++;
         $display("FAIL reset_issue got=%h want=%h", iss_o, {1'b0, 3'd1});
      end
      @(negedge clk);
      RST = 1'b0;
      #1;
      total++;
      if (alu_o !== 69'd0) begin
         bad++;
         $display("FAIL reset_release_alu got=%h want=0", alu_o);
      end
      @(negedge clk);
   endtask

   task automatic test_basic_add();
      bus.aluReady = 1'b1;
      drive_issue(OP_ADD, 3'd0, 32'd5, 3'd0, 32'd7);
      #1;
      total++;
      if (iss_o !== {1'b0, 3'd1}) begin
         bad++;
         $display("FAIL basic_issue_tag got=%h want=%h", iss_o, {1'b0, 3'd1});
      end
      total++;
      if (alu_o !== 69'd0) begin
         bad++;
         $display("FAIL basic_no_bypass got=%h want=0", alu_o);
      end
      @(negedge clk);
      idle();
      #1;
      total++;
      if (alu_o !== {1'b1, OP_ADD, 3'd1, 32'd5, 32'd7}) begin
         bad++;
         $display("FAIL basic_dispatch got=%h want=%h", alu_o, {1'b1, OP_ADD, 3'd1, 32'd5, 32'd7});
      end
      @(negedge clk);
      #1;
      total++;
      if ({alu_o, iss_o} !== {69'd0, 1'b0, 3'd2}) begin
         bad++;
         $display("FAIL basic_exec got=%h want=%h", {alu_o, iss_o}, {69'd0, 1'b0, 3'd2});
      end
      drive_cdb(3'd1, 32'd12);
      @(negedge clk);
      idle();
      #1;
      total++;
      if (iss_o !== {1'b0, 3'd1}) begin
         bad++;
         $display("FAIL basic_release got=%h want=%h", iss_o, {1'b0, 3'd1});
      end
   endtask

   task automatic test_wakeup();
      bus.aluReady = 1'b1;
      drive_issue(OP_SUB, 3'd6, 32'd0, 3'd0, 32'd3);
      @(negedge clk);
      idle();
      #1;
      total++;
      if (alu_o !== 69'd0) begin
         bad++;
         $display("FAIL wake_waiting got=%h want=0", alu_o);
      end
      drive_cdb(3'd6, 32'd20);
      @(negedge clk);
      idle();
      #1;
      total++;
      if (alu_o !== {1'b1, OP_SUB, 3'd1, 32'd20, 32'd3}) begin
         bad++;
         $display("FAIL wake_dispatch got=%h want=%h", alu_o, {1'b1, OP_SUB, 3'd1, 32'd20, 32'd3});
      end
      @(negedge clk);
      drive_cdb(3'd1, 32'd17);
      @(negedge clk);
      idle();
      #1;
      total++;
      if (iss_o !== {1'b0, 3'd1}) begin
         bad++;
         $display("FAIL wake_release got=%h want=%h", iss_o, {1'b0, 3'd1});
      end
   endtask

   task automatic test_issue_capture();
      bus.aluReady = 1'b1;
      drive_issue(OP_ADD, 3'd0, 32'd4, 3'd5, 32'd0);
      drive_cdb(3'd5, 32'd9);
      @(negedge clk);
      idle();
      #1;
      total++;
      if (alu_o !== {1'b1, OP_ADD, 3'd1, 32'd4, 32'd9}) begin
         bad++;
         $display("FAIL capture_dispatch got=%h want=%h", alu_o, {1'b1, OP_ADD, 3'd1, 32'd4, 32'd9});
      end
      @(negedge clk);
      drive_cdb(3'd1, 32'd13);
      @(negedge clk);
      idle();
      #1;
      total++;
      if ({alu_o, iss_o} !== {69'd0, 1'b0, 3'd1}) begin
         bad++;
         $display("FAIL capture_release got=%h want=%h", {alu_o, iss_o}, {69'd0, 1'b0, 3'd1});
      end
   endtask

   task automatic test_full();
      apply_reset();
      drive_issue(OP_ADD, 3'd7, 32'd0, 3'd0, 32'd1);
      #1;
      total++;
      if (iss_o !== {1'b0, 3'd1}) begin
         bad++;
         $display("FAIL full_tag1 got=%h want=%h", iss_o, {1'b0, 3'd1});
      end
      @(negedge clk);
      drive_issue(OP_ADD, 3'd0, 32'd1, 3'd0, 32'd2);
      #1;
      total++;
      if ({alu_o, iss_o} !== {69'd0, 1'b0, 3'd2}) begin
         bad++;
         $display("FAIL full_tag2 got=%h want=%h", {alu_o, iss_o}, {69'd0, 1'b0, 3'd2});
      end
      @(negedge clk);
      bus.aluReady = 1'b1;
      drive_issue(OP_SUB, 3'd0, 32'd30, 3'd7, 32'd0);
      #1;
      total++;
      if ({alu_o, iss_o} !== {1'b1, OP_ADD, 3'd2, 32'd1, 32'd2, 1'b0, 3'd3}) begin
         bad++;
         $display("FAIL full_tag3 got=%h want=%h", {alu_o, iss_o},
                  {1'b1, OP_ADD, 3'd2, 32'd1, 32'd2, 1'b0, 3'd3});
      end
      @(negedge clk);
      idle();
      #1;
      total++;
      if ({alu_o, iss_o} !== {69'd0, 1'b1, 3'd0}) begin
         bad++;
         $display("FAIL full_flag got=%h want=%h", {alu_o, iss_o}, {69'd0, 1'b1, 3'd0});
      end
      // Release and a fourth issue in the same cycle: the issue must still be refused.
      drive_issue(OP_ADD, 3'd0, 32'd100, 3'd0, 32'd200);
      drive_cdb(3'd2, 32'd3);
      #1;
      total++;
      if (iss_o !== {1'b1, 3'd0}) begin
         bad++;
         $display("FAIL full_same_cycle got=%h want=%h", iss_o, {1'b1, 3'd0});
      end
      @(negedge clk);
      idle();
      #1;
      total++;
      if ({alu_o, iss_o} !== {69'd0, 1'b0, 3'd2}) begin
         bad++;
         $display("FAIL full_freed got=%h want=%h", {alu_o, iss_o}, {69'd0, 1'b0, 3'd2});
      end
   endtask

   task automatic test_back_to_back();
      apply_reset();
      drive_issue(OP_ADD, 3'd0, 32'd10, 3'd0, 32'd11);
      @(negedge clk);
      drive_issue(OP_SUB, 3'd0, 32'd20, 3'd0, 32'd21);
      @(negedge clk);
      idle();
      for (int c = 0; c < 3; c++) begin
         #1;
         total++;
         if (alu_o !== {1'b1, OP_ADD, 3'd1, 32'd10, 32'd11}) begin
            bad++;
            $display("FAIL hold_%0d got=%h want=%h", c, alu_o,
                     {1'b1, OP_ADD, 3'd1, 32'd10, 32'd11});
         end
         @(negedge clk);
      end
      bus.aluReady = 1'b1;
      #1;
      total++;
      if (alu_o !== {1'b1, OP_ADD, 3'd1, 32'd10, 32'd11}) begin
         bad++;
         $display("FAIL b2b_first got=%h want=%h", alu_o, {1'b1, OP_ADD, 3'd1, 32'd10, 32'd11});
      end
      @(negedge clk);
      #1;
      total++;
      if (alu_o !== {1'b1, OP_SUB, 3'd2, 32'd20, 32'd21}) begin
         bad++;
         $display("FAIL b2b_second got=%h want=%h", alu_o, {1'b1, OP_SUB, 3'd2, 32'd20, 32'd21});
      end
      @(negedge clk);
      #1;
      total++;
      if ({alu_o, iss_o} !== {69'd0, 1'b0, 3'd3}) begin
         bad++;
         $display("FAIL b2b_drained got=%h want=%h", {alu_o, iss_o}, {69'd0, 1'b0, 3'd3});
      end
   endtask

   task automatic test_reset_mid_op();
      apply_reset();
      bus.aluReady = 1'b1;
      drive_issue(OP_ADD, 3'd0, 32'd1, 3'd0, 32'd1);
      @(negedge clk);
      drive_issue(OP_ADD, 3'd4, 32'd0, 3'd0, 32'd6);
      @(negedge clk);
      drive_issue(OP_SUB, 3'd0, 32'd3, 3'd0, 32'd3);
      @(negedge clk);
      idle();
      bus.aluReady = 1'b0;
      #1;
      total++;
      if (alu_o !== {1'b1, OP_SUB, 3'd3, 32'd3, 32'd3}) begin
         bad++;
         $display("FAIL mid_pre got=%h want=%h", alu_o, {1'b1, OP_SUB, 3'd3, 32'd3, 32'd3});
      end
      RST = 1'b1;
      #1;
      total++;
      if ({alu_o, iss_o} !== {69'd0, 1'b0, 3'd1}) begin
         bad++;
         $display("FAIL mid_async got=%h want=%h", {alu_o, iss_o}, {69'd0, 1'b0, 3'd1});
      end
      @(negedge clk);
      RST = 1'b0;
      bus.aluReady = 1'b1;
      #1;
      total++;
      if (alu_o !== 69'd0) begin
         bad++;
         $display("FAIL mid_after_reset got=%h want=0", alu_o);
      end
      drive_cdb(3'd1, 32'd55);
      @(negedge clk);
      drive_cdb(3'd4, 32'd66);
      #1;
      total++;
      if ({alu_o, iss_o} !== {69'd0, 1'b0, 3'd1}) begin
         bad++;
         $display("FAIL mid_old_tag1 got=%h want=%h", {alu_o, iss_o}, {69'd0, 1'b0, 3'd1});
      end
      @(negedge clk);
      idle();
      #1;
      total++;
      if ({alu_o, iss_o} !== {69'd0, 1'b0, 3'd1}) begin
         bad++;
         $display("FAIL mid_old_tag4 got=%h want=%h", {alu_o, iss_o}, {69'd0, 1'b0, 3'd1});
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      RST   = 1'b1;
      idle();
      bus.aluReady = 1'b0;
      test_reset();
      test_basic_add();
      test_wakeup();
      test_issue_capture();
      test_full();
      test_back_to_back();
      test_reset_mid_op();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
